// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter_pkg
// Description : Shared types and constants for the two-core data memory
//               arbiter: FSM state encoding, default widths, core indices.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_arbiter_pkg;

  localparam int TAM_DEFAULT  = 16;
  localparam int LMEM_DEFAULT = 8;

  localparam logic CORE0 = 1'b0;
  localparam logic CORE1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-requester round-robin arbiter. Combinational one-hot
//               grant; on a tie the core that was not granted last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import data_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  // Pick the single requester, or the one that lost last time on a tie
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_grant == CORE1) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Shares one single-port synchronous data memory between two
//               cores. Round-robin arbitration, memory command sequencing,
//               read data return and one-cycle done pulse per transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int TAM  = TAM_DEFAULT,
  parameter int Lmem = LMEM_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            core0_load,
  input  logic            core0_write,
  input  logic [TAM-1:0]  core0_addr,
  input  logic [TAM-1:0]  core0_wdata,
  output logic [TAM-1:0]  core0_rdata,
  output logic            core0_stall,
  output logic            core0_done,

  input  logic            core1_load,
  input  logic            core1_write,
  input  logic [TAM-1:0]  core1_addr,
  input  logic [TAM-1:0]  core1_wdata,
  output logic [TAM-1:0]  core1_rdata,
  output logic            core1_stall,
  output logic            core1_done,

  output logic [Lmem-1:0] mem_addr,
  output logic [TAM-1:0]  mem_wdata,
  output logic            mem_we,
  output logic            mem_re,
  input  logic [TAM-1:0]  mem_rdata
);

  state_t            state;
  state_t            state_next;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic              arb_enable;
  logic              last_grant;
  logic              cur_core;
  logic              cur_write;
  logic [1:0]        done_q;

  logic              sel_core;
  logic              sel_write;
  logic [Lmem-1:0]   sel_addr;
  logic [TAM-1:0]    sel_wdata;

  // Upper address bits alias onto the low Lmem bits and are intentionally dropped
  logic              unused_addr_hi;
  assign unused_addr_hi = ^{core0_addr[TAM-1:Lmem], core1_addr[TAM-1:Lmem]};

  assign req         = {core1_load | core1_write, core0_load | core0_write};
  assign arb_enable  = (state == IDLE);
  assign core0_done  = done_q[0];
  assign core1_done  = done_q[1];
  assign core0_stall = req[0] & ~done_q[0];
  assign core1_stall = req[1] & ~done_q[1];

  rr_arbiter2 u_rr_arbiter2 (
    .req        (req),
    .last_grant (last_grant),
    .enable     (arb_enable),
    .grant      (grant)
  );

  // Next-state logic and request mux for the granted core (write beats load)
  always_comb begin
    state_next = state;
    sel_core   = grant[1];
    sel_write  = sel_core ? core1_write : core0_write;
    sel_addr   = sel_core ? core1_addr[Lmem-1:0] : core0_addr[Lmem-1:0];
    sel_wdata  = sel_core ? core1_wdata : core0_wdata;
    case (state)
      IDLE:    if (|grant) state_next = ISSUE;
      ISSUE:   state_next = cur_write ? DONE : RD_WAIT;
      RD_WAIT: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Memory command, grant bookkeeping, read data capture and done pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      core0_rdata <= '0;
      core1_rdata <= '0;
      done_q      <= 2'b00;
      last_grant  <= CORE1;
      cur_core    <= CORE0;
      cur_write   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            mem_we     <= sel_write;
            mem_re     <= ~sel_write;
            last_grant <= sel_core;
            cur_core   <= sel_core;
            cur_write  <= sel_write;
          end
        end
        ISSUE: begin
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          if (cur_write) begin
            done_q[cur_core] <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (cur_core == CORE1) begin
            core1_rdata <= mem_rdata;
          end else begin
            core0_rdata <= mem_rdata;
          end
          done_q[cur_core] <= 1'b1;
        end
        DONE: begin
          done_q <= 2'b00;
        end
        default: begin
          done_q <= 2'b00;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Self-checking bench for data_mem_arbiter with a behavioural
//               single-port memory, a directed transaction table and
//               hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        c0_load = 1'b0, c0_write = 1'b0;
  logic [15:0] c0_addr = '0, c0_wdata = '0;
  logic [15:0] c0_rdata;
  logic        c0_stall, c0_done;
  logic        c1_load = 1'b0, c1_write = 1'b0;
  logic [15:0] c1_addr = '0, c1_wdata = '0;
  logic [15:0] c1_rdata;
  logic        c1_stall, c1_done;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [15:0] mem_rdata = '0;

  logic [15:0] mem [0:255];
  logic        watch_re = 1'b0;
  logic        re_seen  = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int          core;
    logic        ld;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vt [9];

  data_mem_arbiter #(.TAM(16), .Lmem(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .core0_load  (c0_load),
    .core0_write (c0_write),
    .core0_addr  (c0_addr),
    .core0_wdata (c0_wdata),
    .core0_rdata (c0_rdata),
    .core0_stall (c0_stall),
    .core0_done  (c0_done),
    .core1_load  (c1_load),
    .core1_write (c1_write),
    .core1_addr  (c1_addr),
    .core1_wdata (c1_wdata),
    .core1_rdata (c1_rdata),
    .core1_stall (c1_stall),
    .core1_done  (c1_done),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory: write on edge, read data one cycle later
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Sticky flag: any read command while watching
  always @(posedge clk) begin
    if (watch_re && mem_re) re_seen <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int core, input logic ld, input logic wr,
                         input logic [15:0] a, input logic [15:0] d);
    if (core == 0) begin
      c0_load = ld; c0_write = wr; c0_addr = a; c0_wdata = d;
    end else begin
      c1_load = ld; c1_write = wr; c1_addr = a; c1_wdata = d;
    end
  endtask

  function automatic logic get_done(input int core);
    return (core == 0) ? c0_done : c1_done;
  endfunction

  function automatic logic get_stall(input int core);
    return (core == 0) ? c0_stall : c1_stall;
  endfunction

  function automatic logic [15:0] get_rdata(input int core);
    return (core == 0) ? c0_rdata : c1_rdata;
  endfunction

  // One transaction, starting and ending on a falling edge
  task automatic do_op(input int idx, input vec_t v);
    int   cyc;
    logic got;
    cyc = 0;
    got = 1'b0;
    set_req(v.core, v.ld, v.wr, v.addr, v.wdata);
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (get_done(v.core)) got = 1'b1;
    end
    check($sformatf("op%0d latency", idx), cyc, v.lat);
    if (got) begin
      check($sformatf("op%0d stall during done", idx), get_stall(v.core), 1'b0);
      if (v.wr) begin
        check($sformatf("op%0d mem word", idx), mem[v.addr[7:0]], v.wdata);
      end else begin
        check($sformatf("op%0d rdata", idx), get_rdata(v.core), v.exp_rd);
      end
    end
    @(negedge clk);
    check($sformatf("op%0d done width", idx), get_done(v.core), 1'b0);
    set_req(v.core, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   d0, d1, cyc, n0, n1, k;
    logic prev0, prev1;
    vec_t v;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    vt[0] = '{1, 1'b0, 1'b1, 16'h0010, 16'h1234, 2, 16'h0000};
    vt[1] = '{1, 1'b1, 1'b0, 16'h0010, 16'h0000, 3, 16'h1234};
    vt[2] = '{0, 1'b0, 1'b1, 16'h01FF, 16'hBEEF, 2, 16'h0000};
    vt[3] = '{1, 1'b1, 1'b0, 16'h00FF, 16'h0000, 3, 16'hBEEF};
    vt[4] = '{0, 1'b1, 1'b0, 16'h02FF, 16'h0000, 3, 16'hBEEF};
    vt[5] = '{0, 1'b0, 1'b1, 16'h0042, 16'h7777, 2, 16'h0000};
    vt[6] = '{1, 1'b1, 1'b0, 16'h0142, 16'h0000, 3, 16'h7777};
    vt[7] = '{0, 1'b1, 1'b1, 16'h0030, 16'h5A5A, 2, 16'h0000};
    vt[8] = '{1, 1'b1, 1'b0, 16'h0030, 16'h0000, 3, 16'h5A5A};

    // Reset state
    @(negedge clk);
    check("reset mem_we", mem_we, 1'b0);
    check("reset mem_re", mem_re, 1'b0);
    check("reset mem_addr", mem_addr, 8'h00);
    check("reset dones", {c1_done, c0_done}, 2'b00);
    check("reset rdata", {c1_rdata, c0_rdata}, 32'h0);
    rst = 1'b1;

    // Reset in the middle of a read
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    check("mid-read mem_re", mem_re, 1'b1);
    check("mid-read mem_addr", mem_addr, 8'h10);
    #2 rst = 1'b0;
    #1;
    check("async reset mem_re", mem_re, 1'b0);
    check("async reset mem_addr", mem_addr, 8'h00);
    check("async reset done", c0_done, 1'b0);
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no done after reset", {c1_done, c0_done}, 2'b00);
    end
    v = '{0, 1'b0, 1'b1, 16'h0005, 16'hABCD, 2, 16'h0000};
    do_op(100, v);

    // Directed transaction table
    for (int i = 0; i < 9; i++) begin
      if (vt[i].ld && vt[i].wr) watch_re = 1'b1;
      do_op(i, vt[i]);
      watch_re = 1'b0;
    end
    check("load+write never read", re_seen, 1'b0);

    // Simultaneous writes to the same word, core0 wins the first tie
    do_reset();
    set_req(0, 1'b0, 1'b1, 16'h0020, 16'h0001);
    set_req(1, 1'b0, 1'b1, 16'h0020, 16'h0002);
    d0 = 0; d1 = 0; cyc = 0;
    while ((d0 == 0 || d1 == 0) && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (d0 == 0) begin
        check("c1 stalled during c0 op", c1_stall, 1'b1);
        if (c0_done) begin d0 = cyc; c0_write = 1'b0; end
      end
      if (d1 == 0 && c1_done) begin d1 = cyc; c1_write = 1'b0; end
    end
    check("simul c0 done cycle", d0, 2);
    check("simul c1 done cycle", d1, 5);
    check("simul final word", mem[8'h20], 16'h0002);
    @(negedge clk);
    v = '{0, 1'b1, 1'b0, 16'h0020, 16'h0000, 3, 16'h0002};
    do_op(101, v);

    // Fairness: both cores hold loads for eight transactions each
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    set_req(1, 1'b1, 1'b0, 16'h0020, 16'h0000);
    n0 = 0; n1 = 0; k = 0; cyc = 0; prev0 = 1'b0; prev1 = 1'b0;
    while ((n0 < 8 || n1 < 8) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (c0_done && c1_done) check("fair both done", 2'b11, 2'b01);
      if (c0_done) begin
        check($sformatf("fair order %0d", k), 0, k % 2);
        check("fair c0 width", prev0, 1'b0);
        check("fair c0 rdata", c0_rdata, 16'h1234);
        n0++; k++;
        if (n0 == 8) c0_load = 1'b0;
      end
      if (c1_done) begin
        check($sformatf("fair order %0d", k), 1, k % 2);
        check("fair c1 width", prev1, 1'b0);
        check("fair c1 rdata", c1_rdata, 16'h0002);
        n1++; k++;
        if (n1 == 8) c1_load = 1'b0;
      end
      prev0 = c0_done;
      prev1 = c1_done;
    end
    check("fair c0 count", n0, 8);
    check("fair c1 count", n1, 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (c0_done || c1_done) check("fair extra done", {c1_done, c0_done}, 2'b00);
    end
    check("idle after fairness", mem_re, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
